// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data-memory controller with programmable wait
// states, little-endian byte-lane stores, sign/zero-extended loads and a
// one-cycle error pulse for misaligned or illegal-mask requests.
module data_mem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i,
  input  logic        rd_wr_i,
  input  logic [2:0]  mask_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WS_C      = 4'(WAIT_STATES);
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

  // Error check on a request: word needs addr[1:0]=0, half needs addr[0]=0,
  // masks 101..111 are never legal.
  function automatic logic req_err(input logic [2:0] m, input logic [1:0] a);
    logic e;
    case (m)
      3'b000:          e = (a != 2'b00);
      3'b001, 3'b011:  e = a[0];
      3'b010, 3'b100:  e = 1'b0;
      default:         e = 1'b1;
    endcase
    return e;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_wr_q;
  logic [2:0]          mask_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                accept_s, err_in_s, do_access_s, clear_rdata_s;
  logic                acc_rd_s;
  logic [2:0]          acc_mask_s;
  logic [ADDR_W+1:0]   acc_addr_s;
  logic [31:0]         acc_wdata_s;
  logic [ADDR_W-1:0]   acc_idx_s;
  logic [31:0]         word_s, load_s, wlane_s;
  logic [7:0]          byte_s;
  logic [15:0]         half_s;
  logic [3:0]          be_s;
  logic                unused_addr_bits_s;

  // Upper address bits wrap modulo the array size and are deliberately dropped.
  assign unused_addr_bits_s = ^addr_i[31:ADDR_W+2];

  assign accept_s = (state_q == IDLE) && !cs_i;
  assign err_in_s = req_err(mask_i, addr_i[1:0]);

  // Access operands: live inputs on a zero-wait accept edge, captured copy in BUSY.
  always_comb begin
    if (state_q == IDLE) begin
      acc_rd_s    = rd_wr_i;
      acc_mask_s  = mask_i;
      acc_addr_s  = addr_i[ADDR_W+1:0];
      acc_wdata_s = wdata_i;
    end else begin
      acc_rd_s    = rd_wr_q;
      acc_mask_s  = mask_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
  end

  assign acc_idx_s = acc_addr_s[ADDR_W+1:2];

  // Next-state logic, wait counter and access strobe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    do_access_s   = 1'b0;
    clear_rdata_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (err_in_s) begin
            state_d       = DONE;
            cnt_d         = 4'd0;
            clear_rdata_s = rd_wr_i;
          end else if (ZERO_WAIT) begin
            state_d     = DONE;
            cnt_d       = 4'd0;
            do_access_s = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = WS_C;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = DONE;
          do_access_s = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Load path: lane select then sign/zero extension; store path: lane enables.
  always_comb begin
    word_s = mem_q[acc_idx_s];
    byte_s = word_s[{acc_addr_s[1:0], 3'b000} +: 8];
    half_s = acc_addr_s[1] ? word_s[31:16] : word_s[15:0];
    case (acc_mask_s)
      3'b000:  begin load_s = word_s;                      be_s = 4'b1111; wlane_s = acc_wdata_s; end
      3'b001:  begin load_s = {{16{half_s[15]}}, half_s};  be_s = acc_addr_s[1] ? 4'b1100 : 4'b0011; wlane_s = {2{acc_wdata_s[15:0]}}; end
      3'b011:  begin load_s = {16'h0000, half_s};          be_s = acc_addr_s[1] ? 4'b1100 : 4'b0011; wlane_s = {2{acc_wdata_s[15:0]}}; end
      3'b010:  begin load_s = {{24{byte_s[7]}}, byte_s};   be_s = 4'b0001 << acc_addr_s[1:0]; wlane_s = {4{acc_wdata_s[7:0]}}; end
      3'b100:  begin load_s = {24'h000000, byte_s};        be_s = 4'b0001 << acc_addr_s[1:0]; wlane_s = {4{acc_wdata_s[7:0]}}; end
      default: begin load_s = 32'h0000_0000;               be_s = 4'b0000; wlane_s = 32'h0000_0000; end
    endcase
  end

  // Control and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_wr_q <= 1'b0;
      mask_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        rd_wr_q <= rd_wr_i;
        mask_q  <= mask_i;
        addr_q  <= addr_i[ADDR_W+1:0];
        wdata_q <= wdata_i;
        err_q   <= err_in_s;
      end
      if (do_access_s && acc_rd_s) begin
        rdata_q <= load_s;
      end else if (clear_rdata_s) begin
        rdata_q <= 32'h0000_0000;
      end
    end
  end

  // Word array, byte-lane writes on the access edge; contents are never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (do_access_s && !acc_rd_s && !rst && be_s[k]) begin
        mem_q[acc_idx_s][8*k +: 8] <= wlane_s[8*k +: 8];
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign misalign_o = (state_q == DONE) && err_q;
  assign stall_o    = !rst && (((state_q == IDLE) && !cs_i) || (state_q == BUSY));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: three instances with WAIT_STATES of
// 0, 1 and 3 share the bus; only one chip select is driven low at a time.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cs_v = 3'b111;
  logic        rd_wr = 1'b0;
  logic [2:0]  mask = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata_a [3];
  logic        stall_a [3];
  logic        mis_a [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .cs_i(cs_v[0]), .rd_wr_i(rd_wr), .mask_i(mask),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a[0]), .stall_o(stall_a[0]),
    .misalign_o(mis_a[0]));
  data_mem_ctrl #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .cs_i(cs_v[1]), .rd_wr_i(rd_wr), .mask_i(mask),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a[1]), .stall_o(stall_a[1]),
    .misalign_o(mis_a[1]));
  data_mem_ctrl #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .cs_i(cs_v[2]), .rd_wr_i(rd_wr), .mask_i(mask),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a[2]), .stall_o(stall_a[2]),
    .misalign_o(mis_a[2]));

  typedef struct {
    logic        rd;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    int          exp_mis;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance d, starting just after a falling edge. Counts stall
  // cycles, error-pulse cycles (through the following IDLE cycle) and returns
  // rdata sampled in the DONE cycle.
  task automatic run_req(input int d, input logic r, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] w,
                         output int stalls, output int mis_n, output logic [31:0] rv);
    stalls = 0;
    mis_n  = 0;
    rd_wr = r; mask = m; addr = a; wdata = w;
    cs_v[d] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_a[d]) break;
      stalls++;
      mis_n += int'(mis_a[d]);
      @(negedge clk);
    end
    if (stalls >= 39) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: stall never dropped on instance %0d", d);
    end
    mis_n += int'(mis_a[d]);
    rv = rdata_a[d];
    cs_v[d] = 1'b1;
    @(negedge clk);
    #1;
    mis_n += int'(mis_a[d]);
  endtask

  int          st, mc;
  logic [31:0] rv;

  initial begin
    //             rd    mask    addr          wdata         exp_rdata   st mis
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 2, 0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2, 0};
    vecs[2]  = '{1'b1, 3'b010, 32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 2, 0};
    vecs[3]  = '{1'b1, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_00DE, 2, 0};
    vecs[4]  = '{1'b1, 3'b010, 32'h0000_0100, 32'h0,         32'hFFFF_FFEF, 2, 0};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'hFFFF_FFEF, 2, 0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0000_0100, 32'h0,         32'h1234_BEEF, 2, 0};
    vecs[7]  = '{1'b1, 3'b011, 32'h0000_0100, 32'h0,         32'h0000_BEEF, 2, 0};
    vecs[8]  = '{1'b1, 3'b001, 32'h0000_0100, 32'h0,         32'hFFFF_BEEF, 2, 0};
    vecs[9]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_0000, 1, 1};
    vecs[10] = '{1'b0, 3'b001, 32'h0000_0103, 32'h0000_5555, 32'h0000_0000, 1, 1};
    vecs[11] = '{1'b1, 3'b000, 32'h0000_0100, 32'h0,         32'h1234_BEEF, 2, 0};
    vecs[12] = '{1'b1, 3'b110, 32'h0000_0100, 32'h0,         32'h0000_0000, 1, 1};
    vecs[13] = '{1'b1, 3'b001, 32'h0000_0102, 32'h0,         32'h0000_1234, 2, 0};
    vecs[14] = '{1'b0, 3'b010, 32'h0000_0101, 32'hFFFF_FF80, 32'h0000_1234, 2, 0};
    vecs[15] = '{1'b1, 3'b010, 32'h0000_0101, 32'h0,         32'hFFFF_FF80, 2, 0};
    vecs[16] = '{1'b1, 3'b000, 32'h0000_1100, 32'h0,         32'h1234_80EF, 2, 0};
    vecs[17] = '{1'b0, 3'b100, 32'h0000_0102, 32'h0000_0007, 32'h1234_80EF, 2, 0};

    // Reset state.
    @(negedge clk);
    #1;
    chk("reset_stall", 32'(stall_a[1]), 32'h0);
    chk("reset_mis",   32'(mis_a[1]),   32'h0);
    chk("reset_rdata", rdata_a[1],      32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Table-driven accesses on the WAIT_STATES=1 instance.
    for (int v = 0; v < 18; v++) begin
      run_req(1, vecs[v].rd, vecs[v].mask, vecs[v].addr, vecs[v].wdata, st, mc, rv);
      chk($sformatf("vec%0d_stalls", v), 32'(st), 32'(vecs[v].exp_stalls));
      chk($sformatf("vec%0d_mis", v),    32'(mc), 32'(vecs[v].exp_mis));
      chk($sformatf("vec%0d_rdata", v),  rv,      vecs[v].exp_rdata);
    end
    run_req(1, 1'b1, 3'b000, 32'h0000_0100, 32'h0, st, mc, rv);
    chk("sbu_then_lw", rv, 32'h1207_80EF);

    // WAIT_STATES=0: single-cycle stall, then a request held through DONE.
    run_req(0, 1'b0, 3'b000, 32'h0000_0020, 32'hCAFE_F00D, st, mc, rv);
    chk("ws0_store_stalls", 32'(st), 32'd1);
    rd_wr = 1'b1; mask = 3'b000; addr = 32'h0000_0020;
    cs_v[0] = 1'b0;
    #1;
    chk("hold_stall_accept", 32'(stall_a[0]), 32'h1);
    @(negedge clk);
    #1;
    chk("hold_stall_done", 32'(stall_a[0]), 32'h0);
    chk("hold_rdata_done", rdata_a[0], 32'hCAFE_F00D);
    @(negedge clk);
    #1;
    chk("hold_reaccept", 32'(stall_a[0]), 32'h1);
    cs_v[0] = 1'b1;
    #1;
    chk("hold_release", 32'(stall_a[0]), 32'h0);
    @(negedge clk);
    #1;
    chk("hold_idle_after", 32'(stall_a[0]), 32'h0);

    // WAIT_STATES=3: reset during BUSY aborts the store.
    run_req(2, 1'b0, 3'b000, 32'h0000_0008, 32'h1111_1111, st, mc, rv);
    chk("ws3_store_stalls", 32'(st), 32'd4);
    run_req(2, 1'b1, 3'b000, 32'h0000_0008, 32'h0, st, mc, rv);
    chk("ws3_load_stalls", 32'(st), 32'd4);
    chk("ws3_load_rdata",  rv,      32'h1111_1111);
    rd_wr = 1'b0; mask = 3'b000; addr = 32'h0000_0008; wdata = 32'hAAAA_AAAA;
    cs_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midbusy_stall", 32'(stall_a[2]), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_stall", 32'(stall_a[2]), 32'h0);
    chk("rst_async_mis",   32'(mis_a[2]),   32'h0);
    chk("rst_async_rdata", rdata_a[2],      32'h0);
    cs_v[2] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_req(2, 1'b1, 3'b000, 32'h0000_0008, 32'h0, st, mc, rv);
    chk("after_abort_rdata", rv, 32'h1111_1111);
    run_req(2, 1'b1, 3'b000, 32'h0000_1008, 32'h0, st, mc, rv);
    chk("alias_rdata", rv, 32'h1111_1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
